// File: rtl/clk_1_crc_ctrl.sv
// -----------------------------------------------------------------------------
// clk_1_crc_ctrl
//
// A clk_1-domain requester for a CRC engine that runs in the clk_2 domain.
// The block accepts one job at a time and holds its message, CRC type and mode
// stable on the clk1_* bus. It launches the job by toggling clk1_flag. It then
// waits for the clk_2 side to toggle clk2_flag back and captures clk2_out. The
// result is returned on a valid/ready output port. A watchdog raises out_err if
// no response arrives within TIMEOUT_CYC cycles of WAIT.
//
// Ports
//   clk_1, rst                 clock and synchronous active-high reset
//   in_valid/in_ready          job request handshake
//   in_message[59:0]           payload: data in the low bits for generate,
//                              codeword in the high bits for check
//   in_CRC                     1 = CRC-5, 0 = CRC-8
//   in_mode                    1 = check, 0 = generate
//   out_valid/out_ready        result handshake
//   out_data[59:0]             captured clk2_out (0 on timeout)
//   out_chk_fail               check job whose engine result is all ones
//   out_err                    watchdog timeout
//   busy                       FSM is not in IDLE
//   clk1_message/CRC/mode      registered job fields driven to the clk_2 domain
//   clk1_flag                  request toggle level
//   clk2_out[59:0], clk2_flag  response data and response toggle level (async)
//   dbg_state[2:0]             current FSM state, for observation only
//
// Handshake semantics (both ports): a transfer happens on a rising clk_1 edge
// where valid && ready are both high. The source holds valid and its payload
// until that transfer. ready may depend on internal state but never on valid.
// -----------------------------------------------------------------------------
module clk_1_crc_ctrl #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk_1,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [59:0] in_message,
  input  logic        in_CRC,
  input  logic        in_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [59:0] out_data,
  output logic        out_chk_fail,
  output logic        out_err,
  output logic        busy,
  output logic [59:0] clk1_message,
  output logic        clk1_CRC,
  output logic        clk1_mode,
  output logic        clk1_flag,
  input  logic [59:0] clk2_out,
  input  logic        clk2_flag,
  output logic [2:0]  dbg_state
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(TIMEOUT_CYC);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LAUNCH = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic          resp_sync;
  logic          resp_lvl;
  logic          resp_match;

  assign in_ready   = (state == ST_IDLE) && !out_valid;
  assign busy       = (state != ST_IDLE);
  assign dbg_state  = state;
  // resp_match is high once the clk_2 side has answered the current request,
  // because every request toggles clk1_flag and every answer mirrors it.
  assign resp_match = (resp_lvl == clk1_flag);

  always_ff @(posedge clk_1) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      resp_sync    <= 1'b0;
      resp_lvl     <= 1'b0;
      clk1_message <= '0;
      clk1_CRC     <= 1'b0;
      clk1_mode    <= 1'b0;
      clk1_flag    <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_chk_fail <= 1'b0;
      out_err      <= 1'b0;
    end else begin
      // clk2_flag reaches the FSM only through this two-stage chain. clk2_out
      // is read only after resp_lvl matches. By then clk2_out has been stable
      // for at least two cycles.
      resp_sync <= clk2_flag;
      resp_lvl  <= resp_sync;

      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            clk1_message <= in_message;
            clk1_CRC     <= in_CRC;
            clk1_mode    <= in_mode;
            state        <= ST_LAUNCH;
          end
        end

        // The flag toggles one cycle after the data is registered. As a
        // result, the clk_2 side never sees the toggle before the fields.
        ST_LAUNCH: begin
          clk1_flag <= ~clk1_flag;
          cnt       <= '0;
          state     <= ST_WAIT;
        end

        ST_WAIT: begin
          if (cnt != CNT_SAT) begin
            cnt <= cnt + 1'b1;
          end
          // The response wins over a timeout that fires in the same cycle.
          if (resp_match) begin
            out_data     <= clk2_out;
            out_chk_fail <= clk1_mode && (&clk2_out);
            out_err      <= 1'b0;
            out_valid    <= 1'b1;
            state        <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            out_data     <= '0;
            out_chk_fail <= 1'b0;
            out_err      <= 1'b1;
            out_valid    <= 1'b1;
            state        <= ST_DRAIN;
          end
        end

        ST_DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        // After a timeout the late answer still has to arrive. Otherwise the
        // toggle levels stay mismatched and the next job would see a false
        // response. There is no second timeout; only rst leaves a dead link.
        ST_DRAIN: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
          if ((!out_valid || out_ready) && resp_match) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_1_crc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_1_crc_ctrl
//
// Bench for clk_1_crc_ctrl with TIMEOUT_CYC = 16. A behavioural clk_2-side CRC
// engine answers each request toggle. Its clock ratio can be changed and its
// responses can be paused. CRC-8 uses poly 0x07 and CRC-5 uses poly 0x05,
// both MSB first with init 0. A check job returns 0 for a good codeword and
// all ones otherwise.
// -----------------------------------------------------------------------------
module tb_clk_1_crc_ctrl;

  localparam int TMO = 16;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LAUNCH = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [59:0] ONES = {60{1'b1}};

  // ---------------- clock / reset ----------------
  logic clk_1 = 1'b0;
  logic clk_2 = 1'b0;
  int   clk2_half = 15;
  logic rst = 1'b1;

  always #15 clk_1 = ~clk_1;
  initial begin
    #7;
    forever #(clk2_half) clk_2 = ~clk_2;
  end

  // ---------------- DUT signals ----------------
  logic        in_valid = 1'b0, in_ready;
  logic [59:0] in_message = '0;
  logic        in_CRC = 1'b0, in_mode = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [59:0] out_data;
  logic        out_chk_fail, out_err, busy;
  logic [59:0] clk1_message;
  logic        clk1_CRC, clk1_mode, clk1_flag;
  logic [59:0] clk2_out;
  logic        clk2_flag;
  logic [2:0]  dbg_state;

  clk_1_crc_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .clk_1(clk_1), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_message(in_message), .in_CRC(in_CRC), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_chk_fail(out_chk_fail), .out_err(out_err),
    .busy(busy),
    .clk1_message(clk1_message), .clk1_CRC(clk1_CRC), .clk1_mode(clk1_mode),
    .clk1_flag(clk1_flag),
    .clk2_out(clk2_out), .clk2_flag(clk2_flag),
    .dbg_state(dbg_state)
  );

  // ---------------- reference CRC math ----------------
  function automatic logic [7:0] crc_rem(input logic [59:0] m, input int n, input logic c5);
    logic [7:0] r;
    logic [7:0] mask;
    logic [7:0] poly;
    int top;
    logic fb;
    r    = '0;
    mask = c5 ? 8'h1F : 8'hFF;
    poly = c5 ? 8'h05 : 8'h07;
    top  = c5 ? 4 : 7;
    for (int i = n - 1; i >= 0; i--) begin
      fb = m[i] ^ r[top];
      r  = (r << 1) & mask;
      if (fb) r = r ^ poly;
    end
    return r;
  endfunction

  function automatic logic [59:0] engine(input logic [59:0] m, input logic c5, input logic md);
    int w;
    logic [7:0] r;
    w = c5 ? 5 : 8;
    if (!md) begin
      r = crc_rem(m, 60 - w, c5);
      return (m << w) | 60'(r);
    end
    r = crc_rem(m, 60, c5);
    return (r == 8'h00) ? '0 : ONES;
  endfunction

  // ---------------- behavioural clk_2 side ----------------
  logic resp_en = 1'b1;
  logic s1, s2;
  always @(posedge clk_2) begin
    if (rst) begin
      s1 <= 1'b0; s2 <= 1'b0; clk2_flag <= 1'b0; clk2_out <= '0;
    end else begin
      s1 <= clk1_flag;
      s2 <= s1;
      if (resp_en && (s2 != clk2_flag)) begin
        clk2_out  <= engine(clk1_message, clk1_CRC, clk1_mode);
        clk2_flag <= ~clk2_flag;
      end
    end
  end

  // ---------------- message stability monitor ----------------
  logic        last_flag = 1'b0;
  logic        outstanding = 1'b0;
  logic [59:0] launched = '0;
  int          stable_err = 0;
  always @(negedge clk_1) begin
    if (clk1_flag != last_flag) begin
      launched    = clk1_message;
      outstanding = 1'b1;
    end
    last_flag = clk1_flag;
    if (outstanding && (clk1_message !== launched)) stable_err++;
    if (clk2_flag == clk1_flag) outstanding = 1'b0;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [59:0] exp_q[$];
  logic        exp_md_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int cyc);
    rst = 1'b1;
    repeat (cyc) @(negedge clk_1);
    rst = 1'b0;
  endtask

  // Called and returning at a negedge; the transfer edge lies inside the wait.
  task automatic send_job(input logic [59:0] m, input logic c5, input logic md);
    logic accepted;
    accepted   = 1'b0;
    in_message = m; in_CRC = c5; in_mode = md; in_valid = 1'b1;
    exp_q.push_back(engine(m, c5, md));
    exp_md_q.push_back(md);
    for (int n = 0; n < 300 && !accepted; n++) begin
      if (in_ready) accepted = 1'b1;
      @(negedge clk_1);
    end
    in_valid = 1'b0;
    check("in_accept", 64'(accepted), 64'd1);
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 300) begin
      @(negedge clk_1);
      n++;
    end
    check("out_valid_seen", 64'(out_valid), 64'd1);
  endtask

  task automatic compare_result();
    logic [59:0] want;
    logic        md;
    if (exp_q.size() == 0) begin
      check("exp_q_nonempty", 64'(exp_q.size()), 64'd1);
    end else begin
      want = exp_q.pop_front();
      md   = exp_md_q.pop_front();
      check("out_data", 64'(out_data), 64'(want));
      check("out_chk_fail", 64'(out_chk_fail), 64'(md && (&want)));
      check("out_err", 64'(out_err), 64'd0);
    end
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    @(negedge clk_1);
    out_ready = 1'b0;
  endtask

  task automatic run_job(input logic [59:0] m, input logic c5, input logic md);
    send_job(m, c5, md);
    wait_out();
    compare_result();
    take_out();
  endtask

  // ---------------- directed sequence ----------------
  logic [59:0] msg, cw, data, held;
  logic [7:0]  r;
  int          cyc;
  logic        saw_valid;
  int          half_tab[3];

  initial begin
    do_reset(8);
    // reset state
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_flag", 64'(clk1_flag), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_message", 64'(clk1_message), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));

    // 1: generate CRC-8
    msg = 60'h0000_0000_0000_0D3;
    r   = crc_rem(msg, 52, 1'b0);
    send_job(msg, 1'b0, 1'b0);
    wait_out();
    check("t1_data", 64'(out_data), 64'({msg[51:0], r}));
    check("t1_err", 64'(out_err), 64'd0);
    check("t1_chk", 64'(out_chk_fail), 64'd0);
    check("t1_flag", 64'(clk1_flag), 64'd1);
    void'(exp_q.pop_front());
    void'(exp_md_q.pop_front());
    take_out();

    // 2: check CRC-5, good codeword then bit 0 flipped
    data = 60'({$urandom(), $urandom()});
    r    = crc_rem(data, 55, 1'b1);
    cw   = {data[54:0], r[4:0]};
    send_job(cw, 1'b1, 1'b1);
    wait_out();
    check("t2_good_data", 64'(out_data), 64'd0);
    check("t2_good_chk", 64'(out_chk_fail), 64'd0);
    void'(exp_q.pop_front());
    void'(exp_md_q.pop_front());
    take_out();
    send_job(cw ^ 60'd1, 1'b1, 1'b1);
    wait_out();
    check("t2_bad_data", 64'(out_data), 64'(ONES));
    check("t2_bad_chk", 64'(out_chk_fail), 64'd1);
    void'(exp_q.pop_front());
    void'(exp_md_q.pop_front());
    take_out();

    // 3: output back-pressure for 20 cycles with a pending request
    send_job(60'({$urandom(), $urandom()}), 1'b0, 1'b0);
    wait_out();
    held = out_data;
    compare_result();
    in_message = 60'({$urandom(), $urandom()});
    in_CRC = 1'b1; in_mode = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("t3_hold_valid", 64'(out_valid), 64'd1);
      check("t3_hold_data", 64'(out_data), 64'(held));
      check("t3_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk_1);
    end
    out_ready = 1'b1;
    @(negedge clk_1);
    out_ready = 1'b0;
    check("t3_after_take_valid", 64'(out_valid), 64'd0);
    check("t3_not_yet_accepted", 64'(dbg_state), 64'(ST_IDLE));
    check("t3_ready_back", 64'(in_ready), 64'd1);
    exp_q.push_back(engine(in_message, 1'b1, 1'b0));
    exp_md_q.push_back(1'b0);
    @(negedge clk_1);
    in_valid = 1'b0;
    check("t3_accepted_next", 64'(dbg_state), 64'(ST_LAUNCH));
    wait_out();
    compare_result();
    take_out();

    // 4: no response -> timeout exactly TMO cycles after entering WAIT
    resp_en = 1'b0;
    send_job(60'({$urandom(), $urandom()}), 1'b0, 1'b0);
    void'(exp_q.pop_back());
    void'(exp_md_q.pop_back());
    check("t4_launch", 64'(dbg_state), 64'(ST_LAUNCH));
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 100) begin
      @(negedge clk_1);
      cyc++;
    end
    check("t4_timeout_cycles", 64'(cyc), 64'(TMO + 1));
    check("t4_err", 64'(out_err), 64'd1);
    check("t4_data", 64'(out_data), 64'd0);
    check("t4_chk", 64'(out_chk_fail), 64'd0);
    take_out();
    saw_valid = 1'b0;
    for (int i = 0; i < 39; i++) begin
      if (in_ready || out_valid) saw_valid = 1'b1;
      @(negedge clk_1);
    end
    check("t4_drain_blocks", 64'(saw_valid), 64'd0);
    resp_en = 1'b1;
    cyc = 0;
    while (in_ready !== 1'b1 && cyc < 100) begin
      if (out_valid) saw_valid = 1'b1;
      @(negedge clk_1);
      cyc++;
    end
    check("t4_ready_back", 64'(in_ready), 64'd1);
    check("t4_late_swallowed", 64'(saw_valid), 64'd0);
    run_job(60'({$urandom(), $urandom()}), 1'b1, 1'b0);

    // 5: clock ratios with back-to-back random jobs
    half_tab[0] = 45; half_tab[1] = 15; half_tab[2] = 5;
    for (int k = 0; k < 3; k++) begin
      clk2_half = half_tab[k];
      for (int j = 0; j < 6; j++) begin
        logic c5, md;
        c5   = 1'($urandom_range(0, 1));
        md   = 1'($urandom_range(0, 1));
        data = 60'({$urandom(), $urandom()});
        if (md && $urandom_range(0, 1) == 1) data = engine(data, c5, 1'b0);
        run_job(data, c5, md);
      end
    end
    check("t5_msg_stable", 64'(stable_err), 64'd0);
    clk2_half = 15;

    // 6: reset during WAIT
    resp_en = 1'b0;
    send_job(60'({$urandom(), $urandom()}), 1'b0, 1'b1);
    void'(exp_q.pop_back());
    void'(exp_md_q.pop_back());
    repeat (4) @(negedge clk_1);
    check("t6_in_wait", 64'(dbg_state), 64'(ST_WAIT));
    rst = 1'b1;
    @(negedge clk_1);
    check("t6_state", 64'(dbg_state), 64'(ST_IDLE));
    check("t6_out_valid", 64'(out_valid), 64'd0);
    check("t6_flag", 64'(clk1_flag), 64'd0);
    check("t6_in_ready", 64'(in_ready), 64'd1);
    resp_en = 1'b1;
    do_reset(6);
    run_job(60'({$urandom(), $urandom()}), 1'b0, 1'b0);
    check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
